mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the two datapath memory ports: port A (instruction fetch) and port B (load/store queue).
- Sits between cpu_datapath's mem_*_a / mem_*_b signals and the single pmem_* interface of the cache/memory.
- Serves one transaction at a time, latching its command, and alternates fairly between A and B when both request.
- Fully sequential: grant FSM, command registers, round-robin pointer and an orphan-response tracker.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-into-one memory port arbiter: instruction fetch (A) and load/store (B)
// share one pmem port, one latched transaction at a time, round-robin on conflict.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MASK_WIDTH    = 2,
  parameter bit INIT_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_a,
  input  logic                  mem_write_a,
  input  logic [MASK_WIDTH-1:0] mem_byte_enable_a,
  input  logic [ADDR_WIDTH-1:0] mem_address_a,
  input  logic [DATA_WIDTH-1:0] mem_wdata_a,
  output logic                  mem_resp_a,
  output logic [DATA_WIDTH-1:0] mem_rdata_a,
  input  logic                  mem_read_b,
  input  logic                  mem_write_b,
  input  logic [MASK_WIDTH-1:0] mem_byte_enable_b,
  input  logic [ADDR_WIDTH-1:0] mem_address_b,
  input  logic [DATA_WIDTH-1:0] mem_wdata_b,
  output logic                  mem_resp_b,
  output logic [DATA_WIDTH-1:0] mem_rdata_b,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [MASK_WIDTH-1:0] pmem_byte_enable,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_ptr;
  logic                  r_orphan;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_be;

  logic w_req_a;
  logic w_req_b;
  logic w_grant;
  logic w_gnt_b;
  logic w_serving;
  logic w_req_cur;
  logic w_deliver;

  assign w_req_a   = mem_read_a | mem_write_a;
  assign w_req_b   = mem_read_b | mem_write_b;
  assign w_serving = (r_state != IDLE);
  assign w_req_cur = (r_state == SERVE_B) ? w_req_b : w_req_a;

  // On completion only the other port is considered, so the finishing
  // requester (still high this cycle) cannot be granted twice in a row.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_gnt_b = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_a && w_req_b) begin
          w_grant = 1'b1;
          w_gnt_b = r_ptr;
        end else if (w_req_a) begin
          w_grant = 1'b1;
        end else if (w_req_b) begin
          w_grant = 1'b1;
          w_gnt_b = 1'b1;
        end
      end
      SERVE_A: begin
        if (pmem_resp) begin
          if (w_req_b) begin
            w_grant = 1'b1;
            w_gnt_b = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      SERVE_B: begin
        if (pmem_resp) begin
          if (w_req_a) w_grant = 1'b1;
          else         w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_grant) w_next = w_gnt_b ? SERVE_B : SERVE_A;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= INIT_PRIORITY;
      r_orphan <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_ptr <= ~w_gnt_b;
        if (w_gnt_b) begin
          r_wr    <= mem_write_b;
          r_rd    <= mem_read_b & ~mem_write_b;
          r_addr  <= mem_address_b;
          r_wdata <= mem_wdata_b;
          r_be    <= mem_byte_enable_b;
        end else begin
          r_wr    <= mem_write_a;
          r_rd    <= mem_read_a & ~mem_write_a;
          r_addr  <= mem_address_a;
          r_wdata <= mem_wdata_a;
          r_be    <= mem_byte_enable_a;
        end
      end
      // A dropped request still finishes in memory, but its response is swallowed.
      if (w_serving && pmem_resp)
        r_orphan <= 1'b0;
      else if (w_serving && !w_req_cur)
        r_orphan <= 1'b1;
    end
  end

  assign pmem_read        = w_serving & r_rd;
  assign pmem_write       = w_serving & r_wr;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;
  assign pmem_byte_enable = r_be;

  assign w_deliver   = w_serving & pmem_resp & ~r_orphan & w_req_cur;
  assign mem_resp_a  = w_deliver & (r_state == SERVE_A);
  assign mem_resp_b  = w_deliver & (r_state == SERVE_B);
  assign mem_rdata_a = mem_resp_a ? pmem_rdata : '0;
  assign mem_rdata_b = mem_resp_b ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention sequence
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam int   NROWS = 30;
  localparam int   NRAND = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_a, mem_write_a;
  logic [1:0]  mem_byte_enable_a;
  logic [15:0] mem_address_a, mem_wdata_a;
  logic        mem_resp_a;
  logic [15:0] mem_rdata_a;
  logic        mem_read_b, mem_write_b;
  logic [1:0]  mem_byte_enable_b;
  logic [15:0] mem_address_b, mem_wdata_b;
  logic        mem_resp_b;
  logic [15:0] mem_rdata_b;
  logic        pmem_read, pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address, pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  int nerr = 0;
  int nchk = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .INIT_PRIORITY(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_a(mem_read_a), .mem_write_a(mem_write_a),
    .mem_byte_enable_a(mem_byte_enable_a), .mem_address_a(mem_address_a),
    .mem_wdata_a(mem_wdata_a), .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_address_b(mem_address_b),
    .mem_wdata_b(mem_wdata_b), .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ra, wa, rb, wb;
    logic [15:0] adda, addb, wdb;
    logic [1:0]  beb;
    logic        resp;
    logic [15:0] rdata;
    logic        e_rd, e_wr;
    logic [15:0] e_addr, e_wd;
    logic [1:0]  e_be;
    logic        e_ra, e_rb;
    logic [15:0] e_rda, e_rdb;
  } vec_t;

  typedef struct {
    logic        wr, rd;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
  } cmd_t;

  vec_t tbl [NROWS];

  function automatic logic [69:0] observed();
    return {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
            mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (rd,wr,addr,wdata,be,resp_a,resp_b,rdata_a,rdata_b)",
               name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_a = 0; mem_write_a = 0; mem_byte_enable_a = '0;
    mem_address_a = '0; mem_wdata_a = '0;
    mem_read_b = 0; mem_write_b = 0; mem_byte_enable_b = '0;
    mem_address_b = '0; mem_wdata_b = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  // Reference model: who owns the memory, what command it holds,
  // whether the owner walked away, and which port wins the next tie.
  int   m_owner;
  bit   m_abandon;
  int   m_favor;
  cmd_t m_cmd;

  function automatic cmd_t take(input int p);
    cmd_t c;
    if (p == 0) begin
      c.wr = mem_write_a; c.rd = mem_read_a & ~mem_write_a;
      c.addr = mem_address_a; c.wdata = mem_wdata_a; c.be = mem_byte_enable_a;
    end else begin
      c.wr = mem_write_b; c.rd = mem_read_b & ~mem_write_b;
      c.addr = mem_address_b; c.wdata = mem_wdata_b; c.be = mem_byte_enable_b;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_abandon = 0; m_favor = 0;
    m_cmd = '{wr: 1'b0, rd: 1'b0, addr: 16'h0, wdata: 16'h0, be: 2'b00};
  endtask

  function automatic logic [69:0] model_expect();
    bit   req [2];
    logic busy, ra, rb;
    logic [15:0] da, db;
    req[0] = mem_read_a | mem_write_a;
    req[1] = mem_read_b | mem_write_b;
    busy = (m_owner >= 0);
    ra = (m_owner == 0) && pmem_resp && !m_abandon && req[0];
    rb = (m_owner == 1) && pmem_resp && !m_abandon && req[1];
    da = ra ? pmem_rdata : 16'h0;
    db = rb ? pmem_rdata : 16'h0;
    return {busy & m_cmd.rd, busy & m_cmd.wr, m_cmd.addr, m_cmd.wdata, m_cmd.be,
            ra, rb, da, db};
  endfunction

  task automatic model_step();
    bit req [2];
    int q;
    req[0] = mem_read_a | mem_write_a;
    req[1] = mem_read_b | mem_write_b;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (req[0] || req[1]) begin
        q = (req[0] && req[1]) ? m_favor : (req[0] ? 0 : 1);
        m_owner = q; m_cmd = take(q); m_favor = 1 - q;
      end
    end else if (pmem_resp) begin
      m_abandon = 0;
      q = 1 - m_owner;
      if (req[q]) begin
        m_owner = q; m_cmd = take(q); m_favor = 1 - q;
      end else begin
        m_owner = -1;
      end
    end else if (!req[m_owner]) begin
      m_abandon = 1;
    end
  endtask

  initial begin
    //        rst ra wa rb wb adda      addb      wdb       beb    resp rdata     e_rd e_wr e_addr    e_wd      e_be   e_ra e_rb e_rda     e_rdb
    tbl[0]  = '{I, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h0000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[1]  = '{O, I, O, O, O, 16'h1000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h0000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[2]  = '{O, I, O, O, O, 16'h1000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h1000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[3]  = '{O, I, O, O, O, 16'h1000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h1000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[4]  = '{O, I, O, O, O, 16'h1000, 16'h0000, 16'h0000, 2'b00, I, 16'hBEEF, I, O, 16'h1000, 16'h0000, 2'b00, I, O, 16'hBEEF, 16'h0000};
    tbl[5]  = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h1000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[6]  = '{I, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h1000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[7]  = '{O, I, O, O, I, 16'h2000, 16'h3004, 16'h55AA, 2'b10, O, 16'h0000, O, O, 16'h0000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[8]  = '{O, I, O, O, I, 16'h2000, 16'h3004, 16'h55AA, 2'b10, O, 16'h0000, I, O, 16'h2000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[9]  = '{O, I, O, O, I, 16'h2000, 16'h3004, 16'h55AA, 2'b10, I, 16'h1234, I, O, 16'h2000, 16'h0000, 2'b00, I, O, 16'h1234, 16'h0000};
    tbl[10] = '{O, O, O, O, I, 16'h0000, 16'h3004, 16'h55AA, 2'b10, O, 16'h0000, O, I, 16'h3004, 16'h55AA, 2'b10, O, O, 16'h0000, 16'h0000};
    tbl[11] = '{O, O, O, O, I, 16'h0000, 16'h3004, 16'h55AA, 2'b10, I, 16'h0F0F, O, I, 16'h3004, 16'h55AA, 2'b10, O, I, 16'h0000, 16'h0F0F};
    tbl[12] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h3004, 16'h55AA, 2'b10, O, O, 16'h0000, 16'h0000};
    tbl[13] = '{O, O, O, I, O, 16'h0000, 16'h4000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h3004, 16'h55AA, 2'b10, O, O, 16'h0000, 16'h0000};
    tbl[14] = '{O, O, O, I, O, 16'h0000, 16'h5000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h4000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[15] = '{O, O, O, I, O, 16'h0000, 16'h5000, 16'h0000, 2'b00, I, 16'h4444, I, O, 16'h4000, 16'h0000, 2'b00, O, I, 16'h0000, 16'h4444};
    tbl[16] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h4000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[17] = '{O, I, O, O, O, 16'h6000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h4000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[18] = '{O, I, O, O, O, 16'h6000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h6000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[19] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h6000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[20] = '{O, I, O, O, O, 16'h7000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h6000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[21] = '{O, I, O, O, O, 16'h7000, 16'h0000, 16'h0000, 2'b00, I, 16'hDEAD, I, O, 16'h6000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[22] = '{O, I, O, O, O, 16'h7000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h6000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[23] = '{O, I, O, O, O, 16'h7000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h7000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[24] = '{O, I, O, O, O, 16'h7000, 16'h0000, 16'h0000, 2'b00, I, 16'h7777, I, O, 16'h7000, 16'h0000, 2'b00, I, O, 16'h7777, 16'h0000};
    tbl[25] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h7000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[26] = '{O, O, O, I, O, 16'h0000, 16'h8000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h7000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[27] = '{I, O, O, I, O, 16'h0000, 16'h8000, 16'h0000, 2'b00, O, 16'h0000, I, O, 16'h8000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[28] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, I, 16'h1111, O, O, 16'h0000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};
    tbl[29] = '{O, O, O, O, O, 16'h0000, 16'h0000, 16'h0000, 2'b00, O, 16'h0000, O, O, 16'h0000, 16'h0000, 2'b00, O, O, 16'h0000, 16'h0000};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NROWS; i++) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      mem_read_a    = tbl[i].ra;
      mem_write_a   = tbl[i].wa;
      mem_address_a = tbl[i].adda;
      mem_read_b    = tbl[i].rb;
      mem_write_b   = tbl[i].wb;
      mem_address_b = tbl[i].addb;
      mem_wdata_b   = tbl[i].wdb;
      mem_byte_enable_b = tbl[i].beb;
      pmem_resp     = tbl[i].resp;
      pmem_rdata    = tbl[i].rdata;
      #1;
      check($sformatf("row%0d", i), observed(),
            {tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_be,
             tbl[i].e_ra, tbl[i].e_rb, tbl[i].e_rda, tbl[i].e_rdb});
    end

    // Continuous contention with a zero-wait memory: grants must alternate.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    mem_read_a = 1; mem_address_a = 16'hA000;
    mem_read_b = 1; mem_address_b = 16'hB000;
    pmem_resp = 1; pmem_rdata = 16'h5A5A;
    @(negedge clk);
    reset = 1'b0;
    #1;
    nchk++;
    if (mem_resp_a !== 1'b0 || mem_resp_b !== 1'b0 || pmem_read !== 1'b0) begin
      nerr++;
      $display("FAIL contend_idle: resp_a=%b resp_b=%b rd=%b expected 0 0 0",
               mem_resp_a, mem_resp_b, pmem_read);
    end
    for (int k = 0; k < 8; k++) begin
      logic        ea, eb;
      logic [15:0] ead;
      @(negedge clk);
      #1;
      ea  = (k % 2 == 0);
      eb  = ~ea;
      ead = ea ? 16'hA000 : 16'hB000;
      nchk++;
      if (mem_resp_a !== ea || mem_resp_b !== eb || pmem_address !== ead || pmem_read !== 1'b1) begin
        nerr++;
        $display("FAIL alt%0d: resp_a=%b resp_b=%b addr=%h rd=%b expected %b %b %h 1",
                 k, mem_resp_a, mem_resp_b, pmem_address, pmem_read, ea, eb, ead);
      end
    end

    // Random traffic, including dropped requests, stray responses and resets.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(3) == 0) mem_read_a  = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) mem_write_a = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) mem_read_b  = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) mem_write_b = 1'($urandom_range(1));
      if ($urandom_range(1) == 0) begin
        mem_address_a = 16'($urandom); mem_wdata_a = 16'($urandom);
        mem_byte_enable_a = 2'($urandom);
      end
      if ($urandom_range(1) == 0) begin
        mem_address_b = 16'($urandom); mem_wdata_b = 16'($urandom);
        mem_byte_enable_b = 2'($urandom);
      end
      pmem_resp  = ($urandom_range(2) == 0);
      pmem_rdata = 16'($urandom);
      #1;
      check($sformatf("rand%0d", c), observed(), model_expect());
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
